// File: rtl/kanade_pkg.sv
// Shared types and constants for the fetch slice of the kanade pipeline.
package kanade_pkg;

    localparam int XLEN  = 32;
    localparam int INS_W = 32;

    localparam logic [XLEN-1:0]  PC_STEP = 32'd4;
    localparam logic [INS_W-1:0] INS_NOP = 32'h0000_0000;

    // One buffered fetch result as presented to the IF/ID register.
    typedef struct packed {
        logic [XLEN-1:0]  next_pc;
        logic [INS_W-1:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO of fetch entries with a synchronous flush.
// Flush has priority: a push or pop in the same cycle is ignored.
module fetch_fifo
    import kanade_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  fetch_entry_t    push_data,
    input  logic            pop,
    input  logic            flush,
    output fetch_entry_t    head,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues in-order memory requests under
// a credit limit, buffers responses and presents them to IF/ID.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both high
// at the rising edge. imem_req: once valid is raised the address is held until
// ready, and valid only drops for a redirect or reset. imem_rsp has no ready:
// every valid cycle is one response, in request order. fd: ins/next_pc are
// stable while fd_valid && !fd_ready.
module if_fetch_unit
    import kanade_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INS_W-1:0]  imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              fd_valid,
    input  logic              fd_ready,
    output logic [INS_W-1:0]  fd_ins,
    output logic [XLEN-1:0]   fd_next_pc
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;       // fetch address of the oldest response that will be kept
    logic [CW-1:0]   outstanding;  // all in-flight requests, including ones to be dropped
    logic [CW-1:0]   drop_cnt;     // in-flight requests issued before the last redirect
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    fifo_head;
    fetch_entry_t    hold_q;
    fetch_entry_t    push_entry;
    logic [CW:0]     in_use;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_push;
    logic            fd_pop;

    assign fd_pop = !fifo_empty && fd_ready;

    // A slot being popped this cycle is free by the time any new response can
    // land, so it is already counted as available; this sustains one fetch per
    // cycle with a two-entry buffer and single-cycle memory.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, fd_pop};
    assign credit_ok = in_use < CW1'(FIFO_DEPTH);

    assign imem_req_valid = reset_n && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop   = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_push   = imem_rsp_valid && !rsp_drop;
    assign push_entry = '{next_pc: rsp_pc + PC_STEP, ins: imem_rsp_data};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rsp_push),
        .push_data (push_entry),
        .pop       (fd_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fd_valid   = !fifo_empty;
    assign fd_ins     = fifo_empty ? hold_q.ins     : fifo_head.ins;
    assign fd_next_pc = fifo_empty ? hold_q.next_pc : fifo_head.next_pc;

    // PC, response tagging and credit/drop counters; redirect overrides everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc       <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) pc <= pc + PC_STEP;
                if (rsp_push) rsp_pc <= rsp_pc + PC_STEP;
                if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // Remember the entry on display so the outputs keep their last value once empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '{next_pc: '0, ins: INS_NOP};
        end else if (!fifo_empty) begin
            hold_q <= fifo_head;
        end
    end

    // The credit limit must keep the buffer from overflowing and bound in-flight requests.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(rsp_push && !redirect_valid && fifo_full));
    assert property (@(posedge clk) disable iff (!reset_n)
        outstanding <= CW'(FIFO_DEPTH));

endmodule
